// File: rtl/sipo_deframer_8bit.sv
// Rebuilds MSB-first serial words aligned by frame_start into a one-deep valid/ready output register.
// A word is visible the cycle after its last bit; a word finishing while the held one is unaccepted is dropped (overrun).
module sipo_deframer_8bit #(
  parameter int WIDTH      = 8,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             clr_status,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun,
  output logic             resync_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;

  logic             restart;
  logic             resync_set;
  logic             word_done;
  logic             accept;
  logic             overrun_set;
  logic [WIDTH-1:0] word;

  assign busy = (state == SHIFT);

  always_comb begin
    word        = {shift_reg[WIDTH-2:0], serial_in};
    restart     = bit_en & frame_start;
    // bit_cnt == 0 in SHIFT means a word just completed, so a frame_start here is on time
    resync_set  = restart & busy & (bit_cnt != '0);
    word_done   = bit_en & ~frame_start & busy & (bit_cnt == CW'(WIDTH - 1));
    accept      = word_done & (~out_valid | out_ready);
    overrun_set = word_done & out_valid & ~out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (bit_en) begin
      if (restart || busy) begin
        shift_reg <= word;
      end
      if (restart) begin
        state   <= SHIFT;
        bit_cnt <= CW'(1);
      end else if (word_done) begin
        state   <= CONTINUOUS ? SHIFT : IDLE;
        bit_cnt <= '0;
      end else if (busy) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_data  <= word;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A set event on the same edge as clr_status wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun    <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clr_status) begin
        overrun <= 1'b0;
      end
      if (resync_set) begin
        resync_err <= 1'b1;
      end else if (clr_status) begin
        resync_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deframer_8bit.sv
// Bench for sipo_deframer_8bit: one CONTINUOUS=1 and one CONTINUOUS=0 instance on shared inputs,
// each compared against a word-level reference model plus fixed expected values.
module tb_sipo_deframer_8bit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic serial_in = 1'b0, bit_en = 1'b0, frame_start = 1'b0, out_ready = 1'b0, clr_status = 1'b0;
  logic [W-1:0] d0, d1;
  logic v0, v1, o0, o1, r0, r1, b0, b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sipo_deframer_8bit #(.WIDTH(W), .CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en), .frame_start(frame_start),
    .out_ready(out_ready), .clr_status(clr_status), .out_data(d1), .out_valid(v1),
    .overrun(o1), .resync_err(r1), .busy(b1));

  sipo_deframer_8bit #(.WIDTH(W), .CONTINUOUS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en), .frame_start(frame_start),
    .out_ready(out_ready), .clr_status(clr_status), .out_data(d0), .out_valid(v0),
    .overrun(o0), .resync_err(r0), .busy(b0));

  // Reference model: a word is accumulated arithmetically from its bit count since the frame began
  logic         m_v[2], m_o[2], m_r[2], framed[2];
  logic [W-1:0] m_d[2], pval[2];
  int           plen[2];
  logic         m_nw;
  logic [W-1:0] m_w;
  logic [W-1:0] exp_q0[$], exp_q1[$], got_q0[$], got_q1[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_v[k] = 0; m_o[k] = 0; m_r[k] = 0; framed[k] = 0;
        m_d[k] = '0; pval[k] = '0; plen[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_nw = 0;
        m_w  = '0;
        if (m_v[k] && out_ready) begin
          if (k == 1) exp_q1.push_back(m_d[k]); else exp_q0.push_back(m_d[k]);
        end
        if (clr_status) begin m_o[k] = 0; m_r[k] = 0; end
        if (bit_en) begin
          if (frame_start) begin
            if (framed[k] && plen[k] != 0) m_r[k] = 1;
            framed[k] = 1;
            plen[k]   = 1;
            pval[k]   = W'(serial_in);
          end else if (framed[k]) begin
            pval[k] = W'(pval[k] * 2 + serial_in);
            plen[k] = plen[k] + 1;
          end
          if (plen[k] == W) begin
            m_nw = 1; m_w = pval[k];
            plen[k] = 0; pval[k] = '0;
            framed[k] = (k == 1);
          end
        end
        if (m_nw) begin
          if (!m_v[k] || out_ready) begin m_d[k] = m_w; m_v[k] = 1; end
          else m_o[k] = 1;
        end else if (m_v[k] && out_ready) begin
          m_v[k] = 0;
        end
      end
    end
  end

  // Transfers observed mid-cycle; the handshake inputs are stable until the next rising edge
  always @(negedge clk) begin
    if (!reset) begin
      if (v1 && out_ready) got_q1.push_back(d1);
      if (v0 && out_ready) got_q0.push_back(d0);
    end
  end

  function automatic logic [W+3:0] expv(input int k);
    return {m_v[k], m_d[k], m_o[k], m_r[k], framed[k]};
  endfunction

  function automatic logic [W+3:0] obsv(input int k);
    return (k == 1) ? {v1, d1, o1, r1, b1} : {v0, d0, o0, r0, b0};
  endfunction

  task automatic cyc(input logic en, input logic sb, input logic fs, input logic rdy, input logic clr);
    bit_en = en; serial_in = sb; frame_start = fs; out_ready = rdy; clr_status = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, input logic fs, input int gmin, input int gmax,
                      input logic rdy, input logic rdy_last, input logic clr_last);
    for (int i = 0; i < W; i++) begin
      repeat ($urandom_range(gmax, gmin)) cyc(1'b0, 1'($urandom), 1'($urandom), rdy, 1'b0);
      cyc(1'b1, w[W-1-i], fs && (i == 0), (i == W-1) ? rdy_last : rdy, (i == W-1) ? clr_last : 1'b0);
    end
  endtask

  task automatic do_reset();
    bit_en = 0; serial_in = 0; frame_start = 0; out_ready = 0; clr_status = 0;
    #2 reset = 1;
    #3;
    exp_q0.delete(); exp_q1.delete(); got_q0.delete(); got_q1.delete();
    #2 reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit_en = 1; serial_in = 1; frame_start = 1; out_ready = 1; clr_status = 0;
    #2 reset = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obsv(k) !== '0) begin
        n_fail++; $display("FAIL reset_state dut%0d: got %h required 0", k, obsv(k));
      end
      n_tests++;
      if (obsv(k) !== expv(k)) begin
        n_fail++; $display("FAIL reset_model dut%0d: got %h required %h", k, obsv(k), expv(k));
      end
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    send(8'hA5, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if ({v1, d1, o1, r1, b1} !== {1'b1, 8'hA5, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL basic_word dut1: got %h required %h", {v1, d1, o1, r1, b1}, {1'b1, 8'hA5, 3'b001});
    end
    n_tests++;
    if ({v0, d0, o0, r0, b0} !== {1'b1, 8'hA5, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL basic_word dut0: got %h required %h", {v0, d0, o0, r0, b0}, {1'b1, 8'hA5, 3'b000});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({v1, v0, d1} !== {2'b00, 8'hA5}) begin
      n_fail++; $display("FAIL basic_one_cycle: got v1=%b v0=%b d1=%h required 0 0 a5", v1, v0, d1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'h3C, 1'b1, 1, 1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if ({v1, d1} !== {1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL b2b_first: got v=%b d=%h required 1 3c", v1, d1);
    end
    send(8'hF0, 1'b0, 1, 1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if ({v1, d1, r1} !== {1'b1, 8'hF0, 1'b0}) begin
      n_fail++; $display("FAIL b2b_second dut1: got v=%b d=%h r=%b required 1 f0 0", v1, d1, r1);
    end
    n_tests++;
    if ({v0, d0, b0} !== {1'b0, 8'h3C, 1'b0}) begin
      n_fail++; $display("FAIL b2b_second dut0: got v=%b d=%h busy=%b required 0 3c 0", v0, d0, b0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (got_q1.size() != 2 || got_q0.size() != 1) begin
      n_fail++; $display("FAIL b2b_count: got %0d/%0d transfers required 2/1", got_q1.size(), got_q0.size());
    end else begin
      n_tests++;
      if ({got_q1[0], got_q1[1], got_q0[0]} !== {8'h3C, 8'hF0, 8'h3C}) begin
        n_fail++; $display("FAIL b2b_words: got %h %h / %h required 3c f0 / 3c", got_q1[0], got_q1[1], got_q0[0]);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send(8'h11, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({v1, d1, o1, v0, d0, o0} !== {1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1}) begin
      n_fail++; $display("FAIL overrun_hold: got %b %h %b / %b %h %b required 1 11 1", v1, d1, o1, v0, d0, o0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({v1, d1, o1} !== {1'b0, 8'h11, 1'b1}) begin
      n_fail++; $display("FAIL overrun_drain: got v=%b d=%h o=%b required 0 11 1", v1, d1, o1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({o1, o0} !== 2'b00) begin
      n_fail++; $display("FAIL overrun_clear: got %b%b required 00", o1, o0);
    end
    send(8'h33, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    send(8'h44, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({o1, d1, o0} !== {1'b1, 8'h33, 1'b1}) begin
      n_fail++; $display("FAIL overrun_set_wins: got o=%b d=%h o0=%b required 1 33 1", o1, d1, o0);
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    send(8'h11, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({v1, d1, o1, v0, d0, o0} !== {1'b1, 8'h22, 1'b0, 1'b1, 8'h22, 1'b0}) begin
      n_fail++; $display("FAIL same_edge: got %b %h %b / %b %h %b required 1 22 0", v1, d1, o1, v0, d0, o0);
    end
  endtask

  task automatic test_resync();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom), i == 0, 1'b1, 1'b0);
    send(8'h5A, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({r1, r0} !== 2'b11) begin
      n_fail++; $display("FAIL resync_flag: got %b%b required 11", r1, r0);
    end
    n_tests++;
    if (got_q1.size() != 1 || got_q0.size() != 1) begin
      n_fail++; $display("FAIL resync_count: got %0d/%0d transfers required 1/1", got_q1.size(), got_q0.size());
    end else begin
      n_tests++;
      if ({got_q1[0], got_q0[0]} !== {8'h5A, 8'h5A}) begin
        n_fail++; $display("FAIL resync_word: got %h/%h required 5a", got_q1[0], got_q0[0]);
      end
    end
  endtask

  task automatic test_reset_midword();
    do_reset();
    send(8'h11, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom), i == 0, 1'b0, 1'b0);
    #3 reset = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obsv(k) !== '0) begin
        n_fail++; $display("FAIL async_reset dut%0d: got %h required 0", k, obsv(k));
      end
    end
    exp_q0.delete(); exp_q1.delete(); got_q0.delete(); got_q1.delete();
    #2 reset = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({v1, b1, v0, b0} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_unframed_ignored: got %b required 0000", {v1, b1, v0, b0});
    end
    send(8'hC3, 1'b1, 0, 1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if ({v1, d1, v0, d0} !== {1'b1, 8'hC3, 1'b1, 8'hC3}) begin
      n_fail++; $display("FAIL reset_then_word: got %b %h / %b %h required 1 c3", v1, d1, v0, d0);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(7, 0) == 0) begin
        for (int i = 0; i < $urandom_range(7, 1); i++) cyc(1'b1, 1'($urandom), i == 0, 1'($urandom), 1'b0);
      end
      w = W'($urandom);
      send(w, $urandom_range(3, 0) != 0, 0, 2, 1'($urandom), 1'($urandom), $urandom_range(3, 0) == 0);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obsv(k) !== expv(k)) begin
          n_fail++; $display("FAIL random_word%0d dut%0d: got %h required %h", it, k, obsv(k), expv(k));
        end
      end
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (got_q1.size() != exp_q1.size() || got_q0.size() != exp_q0.size()) begin
      n_fail++; $display("FAIL random_count: got %0d/%0d transfers required %0d/%0d",
                         got_q1.size(), got_q0.size(), exp_q1.size(), exp_q0.size());
    end else begin
      for (int i = 0; i < got_q1.size(); i++) begin
        n_tests++;
        if (got_q1[i] !== exp_q1[i]) begin
          n_fail++; $display("FAIL random_xfer dut1 #%0d: got %h required %h", i, got_q1[i], exp_q1[i]);
        end
      end
      for (int i = 0; i < got_q0.size(); i++) begin
        n_tests++;
        if (got_q0[i] !== exp_q0[i]) begin
          n_fail++; $display("FAIL random_xfer dut0 #%0d: got %h required %h", i, got_q0[i], exp_q0[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_same_edge();
    test_resync();
    test_reset_midword();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deframer_8bit.md
Name: sipo_deframer_8bit

Overview:
- Receive-side counterpart of the 8-bit PISO transmitter: accepts the MSB-first serial bit stream and rebuilds parallel words.
- Frame alignment comes from a frame_start strobe. Completed words go into a one-deep output register with valid/ready handshake.
- Sits directly downstream of the PISO (or its line receiver) and feeds the parallel datapath/consumer.

Parameters:
- WIDTH, 8, word length in bits; minimum 2.
- CONTINUOUS, 1: 1 = after a word completes, the next bit_en starts a new word with no frame_start; 0 = return to IDLE and wait for frame_start.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-high reset.
- serial_in  input  1  serial data bit, MSB first.
- bit_en  input  1  serial_in holds a valid bit this cycle.
- frame_start  input  1  with bit_en, marks serial_in as the MSB of a new word.
- out_ready  input  1  consumer accepts out_data this cycle.
- clr_status  input  1  synchronous clear of the sticky flags.
- out_data  output  WIDTH  assembled word, MSB = first received bit.
- out_valid  output  1  out_data holds an unconsumed word.
- overrun  output  1  sticky: a completed word was dropped.
- resync_err  output  1  sticky: frame_start arrived mid-word.
- busy  output  1  state is SHIFT.

Behaviour:
- Reset (async): state IDLE, shift_reg = 0, bit_cnt = 0, out_data = 0, out_valid = 0, overrun = 0, resync_err = 0, busy = 0. A reset mid-word discards the partial word and any held word.
- Bits are sampled only on clk edges where bit_en = 1. All other inputs are ignored for shifting when bit_en = 0.
- State IDLE:
  - bit_en & frame_start: shift_reg <= {.., serial_in}, bit_cnt <= 1, go to SHIFT.
  - bit_en without frame_start: bit discarded, stay in IDLE.
- State SHIFT:
  - bit_en & !frame_start: shift_reg <= {shift_reg[WIDTH-2:0], serial_in}, bit_cnt++.
  - bit_en & frame_start: partial word discarded. The bit restarts a word (bit_cnt <= 1) and resync_err is set. Exception: frame_start on a bit that is exactly the MSB of the next word is legal and sets no error.
- Word completion happens on the edge that samples bit number WIDTH, i.e. bit_cnt == WIDTH-1 and a bit is sampled:
  - Word value = {shift_reg[WIDTH-2:0], serial_in}.
  - bit_cnt <= 0.
  - Next state: SHIFT if CONTINUOUS=1, IDLE if CONTINUOUS=0.
  - With CONTINUOUS=1, a frame_start on the first bit after completion is legal (no resync_err).
- Latency: out_valid and out_data update on the same edge that samples the last bit, so they are visible the cycle after that bit.
- Output handshake: a transfer occurs on an edge where out_valid & out_ready.
  - Transfer with no new word: out_valid <= 0. out_data holds its last value.
  - New word with out_valid = 0, or with a transfer on the same edge: out_data <= word, out_valid <= 1. No bubble and no overrun.
  - New word with out_valid = 1 and out_ready = 0: the new word is dropped, out_data is unchanged, overrun <= 1.
- out_data must not change while out_valid = 1 and out_ready = 0.
- Sticky flags clear only on clr_status or reset. If clr_status and a set event occur on the same edge, the set wins.
- Bit counter width is clog2(WIDTH)+1. The counter never exceeds WIDTH-1.
- Throughput: one word per WIDTH consecutive bit_en cycles, sustained when out_ready = 1.

Test Plan:
- Basic word: bit_en = 1 continuously, frame_start with the first bit, bits of 0xA5 MSB-first, out_ready = 1. Required: out_data = 0xA5, out_valid high for exactly 1 cycle, starting the cycle after bit 8, no flags set.
- Back-to-back words, CONTINUOUS=1: frame_start only on the first bit, stream 0x3C then 0xF0 with gapped bit_en (every other cycle). Required: two transfers, 0x3C then 0xF0. Then with CONTINUOUS=0 and no frame_start on the second word: only 0x3C is delivered.
- Backpressure and overrun: out_ready = 0, send 0x11 then 0x22. Required: out_data stays 0x11, out_valid = 1, overrun = 1. Raise out_ready: 0x11 transfers, out_valid = 0. clr_status: overrun = 0.
- Same-edge accept and complete: out_valid = 1 holding 0x11, out_ready = 1 on the edge that completes 0x22. Required: out_data = 0x22, out_valid stays 1, overrun = 0.
- Resync: frame_start after 5 bits of a word, followed by 8 bits of 0x5A. Required: resync_err = 1, out_data = 0x5A, the partial word is never output.
- Async reset mid-word, with bit 4 received and out_valid = 1: assert reset between clock edges. Required: all outputs 0 immediately. After release, bits without frame_start are ignored (CONTINUOUS=0 and 1), and the next framed 0xC3 is received correctly.
